// File: rtl/led_frame_shifter.sv
// Serialises a frame of per-LED colour words MSB-first, one bit per handshake, with LED/bit tracking.
// Define LED_FRAME_DBUF_EN to add a shadow register so the next frame can be queued during SEND.
module led_frame_shifter #(
  parameter int NUM_LEDS     = 5,
  parameter int BITS_PER_LED = 24,
  localparam int W   = NUM_LEDS * BITS_PER_LED,
  localparam int LIW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  parameter logic [W-1:0] DEFAULT_FRAME = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   frame_data,
  input  logic           frame_valid,
  output logic           frame_ready,
  input  logic           repeat_mode,
  output logic           bit_out,
  output logic           bit_valid,
  input  logic           bit_ready,
  output logic [LIW-1:0] led_index,
  output logic           frame_done,
  output logic           busy
);

  localparam int CW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(BITS_PER_LED - 1);
  localparam logic [LIW-1:0] LAST_LED = LIW'(NUM_LEDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state, stateNext;
  logic [W-1:0]   shiftReg, shiftNext;
  logic [CW-1:0]  bitCnt, bitCntNext;
  logic [LIW-1:0] ledIdx, ledIdxNext;
  logic           frameDone, frameDoneNext;
  logic           load, lastBit;
`ifdef LED_FRAME_DBUF_EN
  logic [W-1:0]   shadow, shadowNext;
  logic           pending, pendingNext;
`endif

  assign bit_out    = shiftReg[W-1];
  assign bit_valid  = (state == SEND);
  assign busy       = (state == SEND);
  assign led_index  = ledIdx;
  assign frame_done = frameDone;
`ifdef LED_FRAME_DBUF_EN
  assign frame_ready = (state == IDLE) || !pending;
`else
  assign frame_ready = (state == IDLE);
`endif

  assign load    = frame_valid && frame_ready;
  assign lastBit = (ledIdx == LAST_LED) && (bitCnt == LAST_BIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext     = state;
    shiftNext     = shiftReg;
    bitCntNext    = bitCnt;
    ledIdxNext    = ledIdx;
    frameDoneNext = 1'b0;
`ifdef LED_FRAME_DBUF_EN
    shadowNext    = shadow;
    pendingNext   = pending;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          shiftNext  = frame_data;
          bitCntNext = '0;
          ledIdxNext = '0;
          stateNext  = SEND;
        end
      end
      SEND: begin
`ifdef LED_FRAME_DBUF_EN
        if (load) begin
          shadowNext  = frame_data;
          pendingNext = 1'b1;
        end
`endif
        if (bit_ready) begin
          // Rotate rather than shift so the frame is intact again after W bits (repeat mode).
          shiftNext = (shiftReg << 1) | (shiftReg >> (W - 1));
          if (bitCnt == LAST_BIT) begin
            bitCntNext = '0;
            ledIdxNext = ledIdx + 1'b1;
          end else begin
            bitCntNext = bitCnt + 1'b1;
          end
          if (lastBit) begin
            frameDoneNext = 1'b1;
            ledIdxNext    = '0;
            if (!repeat_mode) stateNext = IDLE;
`ifdef LED_FRAME_DBUF_EN
            // A queued frame (or one arriving on this very edge) beats repeat and idle.
            if (pending || load) begin
              shiftNext   = pending ? shadow : frame_data;
              pendingNext = 1'b0;
              stateNext   = SEND;
            end
`endif
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shiftReg  <= DEFAULT_FRAME;
      bitCnt    <= '0;
      ledIdx    <= '0;
      frameDone <= 1'b0;
    end else begin
      shiftReg  <= shiftNext;
      bitCnt    <= bitCntNext;
      ledIdx    <= ledIdxNext;
      frameDone <= frameDoneNext;
    end
  end

`ifdef LED_FRAME_DBUF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= DEFAULT_FRAME;
      pending <= 1'b0;
    end else begin
      shadow  <= shadowNext;
      pending <= pendingNext;
    end
  end
`endif

endmodule

// File: tb/tb_led_frame_shifter.sv
// Self-checking bench for led_frame_shifter: expected bits come from frame[W-1-pos], LED from pos/BITS_PER_LED.
// Covers single-shot, repeat, random stalls, 3x32 geometry, mid-frame reset and (LED_FRAME_DBUF_EN) double buffering.
module tb_led_frame_shifter;

  localparam int N   = 5;
  localparam int BPL = 24;
  localparam int W   = N * BPL;
  localparam int N2  = 3;
  localparam int BPL2 = 32;
  localparam int W2  = N2 * BPL2;
  localparam logic [W-1:0]  FRAME_A = 120'hFF0000_00FF00_0000FF_123456_ABCDEF;
  localparam logic [W2-1:0] FRAME_W = 96'h01020304_A0B0C0D0_FFFFFFFF;
`ifdef LED_FRAME_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [W-1:0] frame_data = '0;
  logic frame_valid = 1'b0, repeat_mode = 1'b0, bit_ready = 1'b0;
  logic frame_ready, bit_out, bit_valid, frame_done, busy;
  logic [2:0] led_index;

  logic [W2-1:0] frame_data2 = '0;
  logic frame_valid2 = 1'b0, repeat_mode2 = 1'b0, bit_ready2 = 1'b1;
  logic frame_ready2, bit_out2, bit_valid2, frame_done2, busy2;
  logic [1:0] led_index2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_frame_shifter #(.NUM_LEDS(N), .BITS_PER_LED(BPL)) dut (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .repeat_mode(repeat_mode), .bit_out(bit_out),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .led_index(led_index),
    .frame_done(frame_done), .busy(busy));

  led_frame_shifter #(.NUM_LEDS(N2), .BITS_PER_LED(BPL2)) dut2 (
    .clk(clk), .reset(reset), .frame_data(frame_data2), .frame_valid(frame_valid2),
    .frame_ready(frame_ready2), .repeat_mode(repeat_mode2), .bit_out(bit_out2),
    .bit_valid(bit_valid2), .bit_ready(bit_ready2), .led_index(led_index2),
    .frame_done(frame_done2), .busy(busy2));

  function automatic logic [W-1:0] rand_frame();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({frame_ready, bit_valid, busy, frame_done, bit_out, led_index} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset: ready=%b valid=%b busy=%b done=%b bit=%b led=%0d, required 1 0 0 0 0 0",
               frame_ready, bit_valid, busy, frame_done, bit_out, led_index);
    end
    reset = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_single();
    int doneCnt = 0;
    repeat_mode = 1'b0; bit_ready = 1'b1;
    frame_data = FRAME_A; frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    for (int p = 0; p < W; p++) begin
      tests++;
      if (bit_valid !== 1'b1 || bit_out !== FRAME_A[W-1-p] || led_index !== 3'(p / BPL) || frame_ready !== DBUF) begin
        fails++;
        $display("FAIL single bit%0d: valid=%b bit=%b led=%0d ready=%b, required 1 %b %0d %b",
                 p, bit_valid, bit_out, led_index, frame_ready, FRAME_A[W-1-p], p / BPL, DBUF);
      end
      if (frame_done) doneCnt++;
      @(negedge clk);
    end
    tests++;
    if (frame_done !== 1'b1 || bit_valid !== 1'b0 || frame_ready !== 1'b1 || busy !== 1'b0 || doneCnt != 0) begin
      fails++;
      $display("FAIL single end: done=%b valid=%b ready=%b busy=%b early_done=%0d, required 1 0 1 0 0",
               frame_done, bit_valid, frame_ready, busy, doneCnt);
    end
    @(negedge clk);
    tests++;
    if (frame_done !== 1'b0) begin
      fails++; $display("FAIL single done_pulse: done=%b, required 0", frame_done);
    end
    $display("[TB] single frame sent, %0d bits", W);
  endtask

  task automatic test_repeat();
    repeat_mode = 1'b1; bit_ready = 1'b1;
    frame_data = FRAME_A; frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    for (int p = 0; p < 3 * W; p++) begin
      tests++;
      if (bit_valid !== 1'b1 || bit_out !== FRAME_A[W-1-(p%W)] || led_index !== 3'((p % W) / BPL) ||
          frame_done !== (p > 0 && p % W == 0)) begin
        fails++;
        $display("FAIL repeat bit%0d: valid=%b bit=%b led=%0d done=%b, required 1 %b %0d %b",
                 p, bit_valid, bit_out, led_index, frame_done, FRAME_A[W-1-(p%W)], (p % W) / BPL,
                 (p > 0 && p % W == 0));
      end
      if (p == 2 * W + 30) repeat_mode = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (frame_done !== 1'b1 || bit_valid !== 1'b0 || frame_ready !== 1'b1) begin
      fails++;
      $display("FAIL repeat end: done=%b valid=%b ready=%b, required 1 0 1", frame_done, bit_valid, frame_ready);
    end
    @(negedge clk);
    $display("[TB] repeat: three frames then idle");
  endtask

  task automatic test_stall();
    logic [W-1:0] f;
    int p = 0, cyc = 0, doneCnt = 0;
    f = rand_frame();
    repeat_mode = 1'b0; bit_ready = 1'b0;
    frame_data = f; frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    while (p < W && cyc < 2000) begin
      tests++;
      if (bit_valid !== 1'b1 || bit_out !== f[W-1-p] || led_index !== 3'(p / BPL) || frame_done !== 1'b0) begin
        fails++;
        $display("FAIL stall bit%0d: valid=%b bit=%b led=%0d done=%b, required 1 %b %0d 0",
                 p, bit_valid, bit_out, led_index, frame_done, f[W-1-p], p / BPL);
      end
      bit_ready = $urandom_range(0, 1) == 1;
      if (bit_ready) p++;
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (p != W) begin
      fails++; $display("FAIL stall timeout: bits=%0d, required %0d", p, W);
    end
    bit_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (frame_done) doneCnt++;
      @(negedge clk);
    end
    tests++;
    if (doneCnt != 1 || bit_valid !== 1'b0) begin
      fails++; $display("FAIL stall done: pulses=%0d valid=%b, required 1 0", doneCnt, bit_valid);
    end
    bit_ready = 1'b1;
    $display("[TB] stalled frame sent in %0d cycles", cyc);
  endtask

  task automatic test_wide();
    repeat_mode2 = 1'b0; bit_ready2 = 1'b1;
    frame_data2 = FRAME_W; frame_valid2 = 1'b1;
    @(negedge clk); frame_valid2 = 1'b0;
    for (int p = 0; p < W2; p++) begin
      tests++;
      if (bit_valid2 !== 1'b1 || bit_out2 !== FRAME_W[W2-1-p] || led_index2 !== 2'(p / BPL2)) begin
        fails++;
        $display("FAIL wide bit%0d: valid=%b bit=%b led=%0d, required 1 %b %0d",
                 p, bit_valid2, bit_out2, led_index2, FRAME_W[W2-1-p], p / BPL2);
      end
      @(negedge clk);
    end
    tests++;
    if (frame_done2 !== 1'b1 || bit_valid2 !== 1'b0 || frame_ready2 !== 1'b1) begin
      fails++;
      $display("FAIL wide end: done=%b valid=%b ready=%b, required 1 0 1", frame_done2, bit_valid2, frame_ready2);
    end
    @(negedge clk);
    $display("[TB] 3x32 frame sent, %0d bits", W2);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] f;
    int doneCnt = 0;
    repeat_mode = 1'b0; bit_ready = 1'b1;
    frame_data = FRAME_A; frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({frame_ready, bit_valid, busy, frame_done, bit_out, led_index} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_mid: ready=%b valid=%b busy=%b done=%b bit=%b led=%0d, required 1 0 0 0 0 0",
               frame_ready, bit_valid, busy, frame_done, bit_out, led_index);
    end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (frame_done || bit_valid) doneCnt++;
      @(negedge clk);
    end
    tests++;
    if (doneCnt != 0) begin
      fails++; $display("FAIL reset_mid quiet: active cycles=%0d, required 0", doneCnt);
    end
    f = rand_frame();
    frame_data = f; frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    for (int p = 0; p < W; p++) begin
      tests++;
      if (bit_valid !== 1'b1 || bit_out !== f[W-1-p] || led_index !== 3'(p / BPL)) begin
        fails++;
        $display("FAIL reset_mid bit%0d: valid=%b bit=%b led=%0d, required 1 %b %0d",
                 p, bit_valid, bit_out, led_index, f[W-1-p], p / BPL);
      end
      @(negedge clk);
    end
    @(negedge clk);
    $display("[TB] reset at bit 50, fresh frame resent");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] fa, fb, expF;
    fa = rand_frame();
    fb = rand_frame();
    bit_ready = 1'b1;
    repeat_mode = DBUF;
    frame_data = fa; frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    for (int p = 0; p < (DBUF ? 3 * W : W); p++) begin
      expF = (DBUF && p >= W) ? fb : fa;
      tests++;
      if (bit_valid !== 1'b1 || bit_out !== expF[W-1-(p%W)] ||
          frame_ready !== (DBUF ? !(p >= 11 && p < W) : 1'b0)) begin
        fails++;
        $display("FAIL b2b bit%0d: valid=%b bit=%b ready=%b, required 1 %b %b",
                 p, bit_valid, bit_out, frame_ready, expF[W-1-(p%W)], (DBUF ? !(p >= 11 && p < W) : 1'b0));
      end
      if (p == 10) begin frame_data = fb; frame_valid = 1'b1; end
      if (p == (DBUF ? 11 : W - 5)) frame_valid = 1'b0;
      if (p == 2 * W + 5) repeat_mode = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (frame_done !== 1'b1 || bit_valid !== 1'b0 || frame_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b end: done=%b valid=%b ready=%b, required 1 0 1", frame_done, bit_valid, frame_ready);
    end
    @(negedge clk);
    $display("[TB] back-to-back frames, double buffer=%0d", DBUF);
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_stall();
    test_wide();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
